// File: rtl/lcd_nibble_driver_if.sv
// Byte request handshake between a host and the LCD nibble driver.
interface lcd_nibble_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_nibble_driver.sv
// HD44780-style 4-bit write driver: runs the power-on init sequence, then
// sends host bytes as two enable-strobed nibbles followed by a settle wait.
module lcd_nibble_driver #(
  parameter int SETUP_CYC     = 16,
  parameter int E_HI_CYC      = 64,
  parameter int GAP_CYC       = 200,
  parameter int CMD_WAIT_CYC  = 8000,
  parameter int CLR_WAIT_CYC  = 340000,
  parameter int PWRUP_CYC     = 3000000,
  parameter int INIT_WAIT_CYC = 820000
) (
  input  logic                sys0_clk,
  input  logic                sys0_rstn,
  lcd_nibble_driver_if.slave  host,
  output logic                init_done,
  output logic                busy,
  output logic [3:0]          lcd_db,
  output logic                lcd_e,
  output logic                lcd_rs,
  output logic                lcd_rw
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = imax(imax(imax(SETUP_CYC, E_HI_CYC), imax(GAP_CYC, CMD_WAIT_CYC)),
                                imax(imax(CLR_WAIT_CYC, PWRUP_CYC), INIT_WAIT_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EHI, GAP, WAIT} state_t;

  function automatic cnt_t ld(input int n);
    return cnt_t'(n - 1);
  endfunction

  // Steps 0-3 are lone high nibbles (3,3,3,2); steps 4-7 are full command bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h20;
      3'd4:             return 8'h28;
      3'd5:             return 8'h0C;
      3'd6:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic       hi_q, hi_d;
  logic       single_q, single_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] nib_q, nib_d;
  logic       rs_q, rs_d;
  logic       init_done_q, init_done_d;
  logic       ready;
  logic [7:0] ib;
  cnt_t       wait_len;

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      state_q     <= PWRUP;
      cnt_q       <= ld(PWRUP_CYC);
      step_q      <= '0;
      hi_q        <= 1'b0;
      single_q    <= 1'b0;
      nib_q       <= '0;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      hi_q        <= hi_d;
      single_q    <= single_d;
      nib_q       <= nib_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge sys0_clk) begin
    byte_q <= byte_d;
  end

  // Clear/home commands need the long settle; the first init nibble has its own wait.
  always_comb begin
    wait_len = ld(CMD_WAIT_CYC);
    if (single_q) begin
      if (step_q == 3'd0) wait_len = ld(INIT_WAIT_CYC);
    end else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03)) begin
      wait_len = ld(CLR_WAIT_CYC);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    hi_d        = hi_q;
    single_d    = single_q;
    byte_d      = byte_q;
    nib_d       = nib_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    ib          = init_byte(step_q);
    case (state_q)
      PWRUP: begin
        if (cnt_q == '0) state_d = INIT;
        else             cnt_d = cnt_q - cnt_t'(1);
      end
      INIT: begin
        state_d  = SETUP;
        cnt_d    = ld(SETUP_CYC);
        rs_d     = 1'b0;
        hi_d     = 1'b1;
        single_d = ~step_q[2];
        byte_d   = ib;
        nib_d    = ib[7:4];
      end
      IDLE: begin
        if (host.in_valid && init_done_q) begin
          state_d  = SETUP;
          cnt_d    = ld(SETUP_CYC);
          rs_d     = host.in_rs;
          byte_d   = host.in_data;
          nib_d    = host.in_data[7:4];
          hi_d     = 1'b1;
          single_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EHI;
          cnt_d   = ld(E_HI_CYC);
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      EHI: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = ld(GAP_CYC);
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (hi_q && !single_q) begin
            state_d = SETUP;
            cnt_d   = ld(SETUP_CYC);
            nib_d   = byte_q[3:0];
            hi_d    = 1'b0;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_len;
          end
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (step_q == 3'd7) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = INIT;
            step_d  = step_q + 3'd1;
          end
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      default: state_d = PWRUP;
    endcase
  end

  assign ready         = (state_q == IDLE) && init_done_q;
  assign host.in_ready = ready;
  assign busy          = ~ready;
  assign init_done     = init_done_q;
  assign lcd_e         = (state_q == EHI);
  assign lcd_db        = nib_q;
  assign lcd_rs        = rs_q;
  assign lcd_rw        = 1'b0;

endmodule
